// File: rtl/md6_shift_sched.sv
// MD6 shift-pair step sequencer: captures the 16-entry r/l shift tables on start and
// issues one (r, l) pair per accepted step over 16*rounds steps. Optional table range
// check is built when MD6_SHIFT_CHECK_EN is defined; otherwise err_o is tied low.
module md6_shift_sched #(
  parameter int ROUND_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [ROUND_W-1:0] rounds_i,
  input  logic [127:0]       rshift_tbl_i,
  input  logic [127:0]       lshift_tbl_i,
  output logic               step_valid_o,
  input  logic               step_ready_i,
  output logic [7:0]         r_amt_o,
  output logic [7:0]         l_amt_o,
  output logic [3:0]         step_idx_o,
  output logic [ROUND_W-1:0] round_idx_o,
  output logic               last_step_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [127:0]       rtbl_q, rtbl_d;
  logic [127:0]       ltbl_q, ltbl_d;
  logic [ROUND_W-1:0] rounds_q, rounds_d;
  logic [3:0]         step_idx_q, step_idx_d;
  logic [ROUND_W-1:0] round_idx_q, round_idx_d;
  logic               tblBad;
  logic               accept;
  logic               lastStep;

`ifdef MD6_SHIFT_CHECK_EN
  logic err_q, err_d;

  // Every entry of both incoming tables must lie in 1..63.
  always_comb begin
    tblBad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (rshift_tbl_i[8*i +: 8] == 8'd0 || rshift_tbl_i[8*i +: 8] > 8'd63) tblBad = 1'b1;
      if (lshift_tbl_i[8*i +: 8] == 8'd0 || lshift_tbl_i[8*i +: 8] > 8'd63) tblBad = 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start_i) err_d = tblBad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign tblBad = 1'b0;
  assign err_o  = 1'b0;
`endif

  assign accept   = (state_q == RUN) && step_ready_i;
  assign lastStep = (state_q == RUN) && (round_idx_q == rounds_q - ROUND_W'(1)) &&
                    (step_idx_q == 4'hF);

  always_comb begin
    state_d     = state_q;
    rtbl_d      = rtbl_q;
    ltbl_d      = ltbl_q;
    rounds_d    = rounds_q;
    step_idx_d  = step_idx_q;
    round_idx_d = round_idx_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          rtbl_d      = rshift_tbl_i;
          ltbl_d      = lshift_tbl_i;
          rounds_d    = rounds_i;
          step_idx_d  = 4'd0;
          round_idx_d = '0;
          state_d     = (tblBad || rounds_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          step_idx_d = step_idx_q + 4'd1;
          if (step_idx_q == 4'hF) round_idx_d = round_idx_q + ROUND_W'(1);
          if (lastStep) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rtbl_q      <= '0;
      ltbl_q      <= '0;
      rounds_q    <= '0;
      step_idx_q  <= 4'd0;
      round_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rtbl_q      <= rtbl_d;
      ltbl_q      <= ltbl_d;
      rounds_q    <= rounds_d;
      step_idx_q  <= step_idx_d;
      round_idx_q <= round_idx_d;
    end
  end

  // Shift amounts come only from the captured tables, so they stay put during stalls.
  assign r_amt_o      = rtbl_q[{step_idx_q, 3'b000} +: 8];
  assign l_amt_o      = ltbl_q[{step_idx_q, 3'b000} +: 8];
  assign step_idx_o   = step_idx_q;
  assign round_idx_o  = round_idx_q;
  assign step_valid_o = (state_q == RUN);
  assign last_step_o  = lastStep;
  assign busy_o       = (state_q == RUN) || (state_q == DONE);
  assign done_o       = (state_q == DONE);

endmodule

// File: doc/md6_shift_sched.md
# md6_shift_sched

Step sequencer for the MD6 compression-function datapath. It captures the packed 16-entry right-shift and left-shift constant tables at start. It then issues one (r, l) shift pair per MD6 step over a valid/ready handshake, cycling index 0..15 once per round for a run-time round count. It sits between the shift-constant ROMs and the step datapath, which consumes one pair per accepted step.

## Interface
- `ROUND_W`, default 8: width of the round counter and of the `rounds` input.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: begin a run; sampled only in IDLE.
- `rounds` in `ROUND_W`: number of rounds; latched on accepted `start`.
- `rshift_tbl` in 128: right-shift table; entry i is bits [8i+7:8i]; latched on accepted `start`.
- `lshift_tbl` in 128: left-shift table, same packing; latched on accepted `start`.
- `step_valid` out 1: current (r, l) pair is valid.
- `step_ready` in 1: consumer accepts the pair when high together with `step_valid`.
- `r_amt` out 8: right-shift amount for the current step.
- `l_amt` out 8: left-shift amount for the current step.
- `step_idx` out 4: current table index, 0..15.
- `round_idx` out `ROUND_W`: current round, 0..`rounds`-1.
- `last_step` out 1: high while presenting the final step of the run.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: table check failure, sticky until the next accepted `start`.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**: `start`=1 latches both tables and `rounds` and clears `step_idx`, `round_idx` and `err`.
  - If `rounds`=0, go to DONE.
  - Otherwise go to RUN.
- **RUN**: `step_valid`=1.
  - `r_amt` = captured `rshift_tbl` entry at `step_idx`; `l_amt` = captured `lshift_tbl` entry at `step_idx`. Both come from registered state only.
  - On accept (`step_valid` & `step_ready`), `step_idx` increments.
  - When `step_idx` wraps from 15 to 0, `round_idx` increments.
  - `last_step` = (`round_idx`==`rounds`-1) & (`step_idx`==15).
  - An accept while `last_step`=1 goes to DONE.
  - `step_ready`=0 holds every output stable. No input-table change after capture affects the run.
- **DONE**: `done`=1 and `step_valid`=0 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored, including in DONE.
- Counter arithmetic is modulo width.
  - `rounds` up to 2^`ROUND_W`-1 is legal.
  - The total number of steps is 16·`rounds`.

## Timing
- Reset values: state=IDLE; `step_valid`, `done`, `busy`, `err` and `last_step` = 0; `step_idx`=0, `round_idx`=0, `r_amt`=0, `l_amt`=0.
- `start` in cycle N gives `busy`=1 and `step_valid`=1 with index 0 in cycle N+1.
- With `step_ready` held high, one step is accepted per cycle.
  - The final accept occurs in cycle N+16·`rounds`.
  - `done` pulses in cycle N+16·`rounds`+1.
  - `busy`=0 from the following cycle.
- `rounds`=0: `done` is in cycle N+1 and no step is issued.
- Assertion of `rst_n`=0 at any point forces the reset values immediately. No `done` is produced for an aborted run.

## Configuration
- Macro: `MD6_SHIFT_CHECK_EN`.
- Defined: on an accepted `start`, every captured entry of both tables is checked for the range 1..63.
  - Any violation sets `err`=1 in cycle N+1 and goes straight to DONE. No steps are issued; `done` pulses in cycle N+1.
- Undefined: no check logic is built; `err` is tied to 0.

## Test plan
- Reset then load MD6 tables (r = 10,5,13,10,11,12,2,7,14,15,7,13,11,7,6,12; l = 11,24,9,16,15,9,27,15,6,2,29,8,15,5,31,9) with `rounds`=2 and `step_ready`=1 -> 32 accepts in cycles N+1..N+32.
  - Accept k shows r[k mod 16], l[k mod 16].
  - `last_step` is high only on the 32nd accept.
  - `done` is in cycle N+33.
- Same run with `step_ready` toggled pseudo-randomly -> outputs hold while stalled; the sequence is identical; the total accept count is 32.
- `rounds`=0 -> no `step_valid`; `done`=1 in cycle N+1; `busy` is high for one cycle.
- `start` pulsed mid-run, and table inputs changed mid-run -> ignored; the sequence is unchanged.
- `rst_n` dropped at step 20 of 32 -> all outputs go to reset values at once; a fresh `start` restarts at index 0, round 0.
- With `MD6_SHIFT_CHECK_EN` defined, set l[14]=64 -> `err`=1 and `done`=1 in cycle N+1 with no `step_valid`; the next valid `start` clears `err`.
